// File: rtl/uart_adder_pkg.sv
// Shared types and constants for the UART adder sequencer.
// Imported by the interface, the timeout counter and the top.
package uart_adder_pkg;

  localparam int OP_BYTES_DEF = 8;

  // upper bits of the carry byte; the carry itself sits in bit 0
  localparam logic [6:0] CARRY_PAD = 7'b0;

  typedef enum logic [1:0] {
    S_RX_A = 2'd0,
    S_RX_B = 2'd1,
    S_WAIT = 2'd2,
    S_TX   = 2'd3
  } state_t;

endpackage

// File: rtl/uart_adder_if.sv
// Byte streams between the UART and the adder sequencer.
// master = host/UART side, slave = sequencer side.
interface uart_adder_if;

  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;

  modport master (
    output rx_data_i,
    output rx_valid_i,
    output tx_ready_i,
    input  tx_data_o,
    input  tx_valid_o
  );

  modport slave (
    input  rx_data_i,
    input  rx_valid_i,
    input  tx_ready_i,
    output tx_data_o,
    output tx_valid_o
  );

endinterface

// File: rtl/uart_adder_timeout.sv
// Loadable down-counter with clear; strobes expire on its last count.
// Used as the inter-byte watchdog of a partial frame.
module uart_adder_timeout #(
  parameter int W    = 1,
  parameter int LOAD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  output logic expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(LOAD);
    end else if (clr) begin
      cnt_q <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // a load on the same cycle means a byte arrived: the byte wins
  assign expire = !load && !clr && (cnt_q == W'(1));

endmodule

// File: rtl/uart_adder_ctrl.sv
// Sequencer around the external carry-select adder: collects A and B
// from the UART, waits for the sum to settle, streams the result back.
import uart_adder_pkg::*;

module uart_adder_ctrl #(
  parameter int OP_BYTES    = OP_BYTES_DEF,
  parameter int ADD_LATENCY = 1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  uart_adder_if.slave           bus,
  output logic [8*OP_BYTES-1:0] add_a_o,
  output logic [8*OP_BYTES-1:0] add_b_o,
  input  logic [8*OP_BYTES-1:0] add_s_i,
  input  logic                  add_cout_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  overrun_o
);

  localparam int OW = 8 * OP_BYTES;
  localparam int RW = 8 * (OP_BYTES + 1);
  localparam int KW = $clog2(OP_BYTES + 1);
  localparam int WW = (ADD_LATENCY > 1) ?
                      $clog2(ADD_LATENCY + 1) : 1;
  localparam int TW = (TIMEOUT_CYC > 0) ?
                      $clog2(TIMEOUT_CYC + 1) : 1;

  state_t          state_q, state_n;
  logic [KW-1:0]   k_q, k_n;
  logic [WW-1:0]   wcnt_q, wcnt_n;
  logic [OW-1:0]   a_q, a_n;
  logic [OW-1:0]   b_q, b_n;
  logic [RW-1:0]   res_q, res_n;
  logic [7:0]      txd_q, txd_n;
  logic            txv_q, txv_n;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic            ovr_q, ovr_n;

  logic            rx_st;
  logic            run;
  logic            tmo_load;
  logic            expire;
  logic            last_k;

  assign rx_st = (state_q == S_RX_A) || (state_q == S_RX_B);
  assign run   = (state_q == S_RX_B) ||
                 ((state_q == S_RX_A) && (k_q != '0));
  assign tmo_load = bus.rx_valid_i && rx_st;
  assign last_k   = (k_q == KW'(OP_BYTES - 1));

  uart_adder_timeout #(
    .W    (TW),
    .LOAD (TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (tmo_load),
    .clr    (!run),
    .expire (expire)
  );

  always_comb begin
    state_n = state_q;
    k_n     = k_q;
    wcnt_n  = wcnt_q;
    a_n     = a_q;
    b_n     = b_q;
    res_n   = res_q;
    txd_n   = txd_q;
    txv_n   = txv_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    ovr_n   = 1'b0;
    unique case (state_q)
      S_RX_A: begin
        if (bus.rx_valid_i) begin
          a_n[8*int'(k_q) +: 8] = bus.rx_data_i;
          if (last_k) begin
            k_n     = '0;
            state_n = S_RX_B;
          end else begin
            k_n = k_q + KW'(1);
          end
        end else if (expire) begin
          err_n = 1'b1;
          k_n   = '0;
        end
      end
      S_RX_B: begin
        if (bus.rx_valid_i) begin
          b_n[8*int'(k_q) +: 8] = bus.rx_data_i;
          if (last_k) begin
            k_n     = '0;
            wcnt_n  = WW'(ADD_LATENCY);
            state_n = S_WAIT;
          end else begin
            k_n = k_q + KW'(1);
          end
        end else if (expire) begin
          err_n   = 1'b1;
          k_n     = '0;
          state_n = S_RX_A;
        end
      end
      S_WAIT: begin
        ovr_n  = bus.rx_valid_i;
        wcnt_n = wcnt_q - WW'(1);
        if (wcnt_q == WW'(1)) begin
          res_n   = {CARRY_PAD, add_cout_i, add_s_i};
          k_n     = '0;
          state_n = S_TX;
        end
      end
      S_TX: begin
        ovr_n = bus.rx_valid_i;
        // first TX cycle only loads the output register
        if (!txv_q) begin
          txv_n = 1'b1;
          txd_n = res_q[8*int'(k_q) +: 8];
        end else if (bus.tx_ready_i) begin
          if (k_q == KW'(OP_BYTES)) begin
            txv_n   = 1'b0;
            done_n  = 1'b1;
            k_n     = '0;
            state_n = S_RX_A;
          end else begin
            k_n   = k_q + KW'(1);
            txd_n = res_q[8*(int'(k_q) + 1) +: 8];
          end
        end
      end
      default: begin
        state_n = S_RX_A;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RX_A;
      k_q     <= '0;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      k_q     <= k_n;
      wcnt_q  <= wcnt_n;
      a_q     <= a_n;
      b_q     <= b_n;
      res_q   <= res_n;
      txd_q   <= txd_n;
      txv_q   <= txv_n;
      done_q  <= done_n;
      err_q   <= err_n;
      ovr_q   <= ovr_n;
    end
  end

  assign bus.tx_data_o  = txd_q;
  assign bus.tx_valid_o = txv_q;
  assign add_a_o   = a_q;
  assign add_b_o   = b_q;
  assign busy_o    = (state_q == S_WAIT) || (state_q == S_TX);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_uart_adder_ctrl.sv
// Directed bench for uart_adder_ctrl with an arithmetic result model.
// Every handshaken byte is checked against the model queue.
module tb_uart_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] add_a, add_b, add_s;
  logic        add_cout;
  logic        busy, done, err, ovr;

  uart_adder_if bus ();

  uart_adder_ctrl #(
    .OP_BYTES    (8),
    .ADD_LATENCY (1),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_s_i    (add_s),
    .add_cout_i (add_cout),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .overrun_o  (ovr)
  );

  // stand-in for the external adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_hs = 0;
  int n_done = 0;
  int n_err = 0;
  int n_ovr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_d = 8'h00;

  task automatic check(input string nm,
                       input logic [71:0] got,
                       input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        check("stall_hold", {63'b0, bus.tx_valid_o, bus.tx_data_o},
              {63'b0, 1'b1, stall_d});
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        n_hs++;
        log_q.push_back(bus.tx_data_o);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra got %0h exp none", bus.tx_data_o);
        end else begin
          check("tx_byte", 72'(bus.tx_data_o), 72'(exp_q.pop_front()));
        end
      end
      stall_q = bus.tx_valid_o && !bus.tx_ready_i;
      stall_d = bus.tx_data_o;
      if (done) n_done++;
      if (err)  n_err++;
      if (ovr)  n_ovr++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    cycle();
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    for (int i = 0; i < 8; i++) exp_q.push_back(s[8*i +: 8]);
    exp_q.push_back({7'b0, s[64]});
  endtask

  task automatic send_frame(input logic [63:0] a, input logic [63:0] b);
    push_exp(a, b);
    for (int i = 0; i < 8; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 8; i++) send_byte(b[8*i +: 8]);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (n_done < target && n < 300) begin
      cycle();
      n++;
    end
    check("done_seen", 72'(n_done >= target), 72'd1);
  endtask

  task automatic check_log(input string nm, input logic [71:0] exp);
    check({nm, "_len"}, 72'(log_q.size()), 72'd9);
    for (int i = 0; i < 9 && i < log_q.size(); i++)
      check(nm, 72'(log_q[i]), 72'(exp[8*i +: 8]));
  endtask

  task automatic check_idle(input string nm);
    check(nm, {62'b0, bus.tx_valid_o, busy, done, err, ovr,
               bus.tx_data_o[4:0]}, 72'd0);
    check({nm, "_ops"}, 72'(add_a | add_b), 72'd0);
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1;
    bus.rx_data_i  = 8'h00;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    repeat (3) cycle();
    check_idle("reset_in");
    rst = 1'b0;
    cycle();
    check_idle("reset_out");
    check("reset_txd", 72'(bus.tx_data_o), 72'd0);

    // case 1: 1 + 2, plus latency and register timing
    log_q.delete();
    base = n_done;
    send_frame(64'h1, 64'h2);
    check("b_loaded", 72'(add_b), 72'd2);
    check("busy_wait", 72'(busy), 72'd1);
    cycle();
    check("txv_n1", 72'(bus.tx_valid_o), 72'd0);
    cycle();
    check("txv_n2", 72'(bus.tx_valid_o), 72'd1);
    check("first_byte", 72'(bus.tx_data_o), 72'h03);
    wait_done(base + 1);
    check("busy_after", 72'(busy), 72'd0);
    repeat (3) cycle();
    check("done_once", 72'(n_done - base), 72'd1);
    check_log("c1", {8'h00, 64'h3});

    // case 2: carry out
    log_q.delete();
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    wait_done(base + 2);
    check_log("c2", {8'h01, 64'h0});

    // case 3: back-pressure on the first and last byte
    log_q.delete();
    base = n_hs;
    bus.tx_ready_i = 1'b0;
    send_frame(64'h1, 64'h2);
    n = 0;
    while (!bus.tx_valid_o && n < 50) begin cycle(); n++; end
    check("stall0_seen", 72'(bus.tx_valid_o), 72'd1);
    repeat (5) cycle();
    bus.tx_ready_i = 1'b1;
    n = 0;
    while (n_hs < base + 8 && n < 50) begin cycle(); n++; end
    bus.tx_ready_i = 1'b0;
    repeat (5) cycle();
    check("stall8_data", 72'(bus.tx_data_o), 72'h00);
    bus.tx_ready_i = 1'b1;
    wait_done(3);
    check("c3_hs", 72'(n_hs - base), 72'd9);
    check_log("c3", {8'h00, 64'h3});

    // case 4: inter-byte timeout
    base = n_err;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      n = i;
      if (err) break;
    end
    check("tmo_cycle", 72'(n), 72'd16);
    repeat (3) cycle();
    check("tmo_once", 72'(n_err - base), 72'd1);
    log_q.delete();
    send_frame(64'h10, 64'h20);
    wait_done(4);
    check_log("c4", {8'h00, 64'h30});

    // byte on the expiry cycle beats the timeout
    log_q.delete();
    base = n_err;
    push_exp(64'h0807_0605_0403_0201, 64'h1010_1010_1010_1010);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (15) cycle();
    send_byte(8'h04);
    for (int i = 4; i < 8; i++) send_byte(8'(i + 1));
    for (int i = 0; i < 8; i++) send_byte(8'h10);
    wait_done(5);
    check("tmo_race", 72'(n_err - base), 72'd0);
    check_log("c4b", {8'h00, 64'h1817_1615_1413_1211});

    // case 5: overrun during TX
    log_q.delete();
    base = n_ovr;
    send_frame(64'h1, 64'h2);
    n = 0;
    while (!bus.tx_valid_o && n < 50) begin cycle(); n++; end
    send_byte(8'h55);
    send_byte(8'h66);
    wait_done(6);
    repeat (2) cycle();
    check("ovr_count", 72'(n_ovr - base), 72'd2);
    check_log("c5", {8'h00, 64'h3});
    log_q.delete();
    send_frame(64'h10, 64'h20);
    wait_done(7);
    check_log("c5b", {8'h00, 64'h30});

    // case 6: reset in the middle of TX
    base = n_hs;
    send_frame(64'h1, 64'h2);
    n = 0;
    while (n_hs < base + 5 && n < 50) begin cycle(); n++; end
    check("pre_rst_txv", 72'(bus.tx_valid_o), 72'd1);
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    check("rst_mid_txd", 72'(bus.tx_data_o), 72'd0);
    exp_q.delete();
    cycle();
    rst = 1'b0;
    cycle();
    log_q.delete();
    base = n_done;
    send_frame(64'h5, 64'h7);
    wait_done(base + 1);
    check_log("c6", {8'h00, 64'hC});
    check("exp_drained", 72'(exp_q.size()), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_adder_ctrl.md
Name: uart_adder_ctrl

Overview:
Sequencer wrapped around the 64-bit carry-select adder in the UART adder datapath.
- Collects two OP_BYTES-byte operands from the UART receiver byte stream.
- Presents the operands to the adder and waits a fixed settle time.
- Captures the sum and carry-out, then streams the result bytes to the UART transmitter over a valid/ready handshake.
- Drops partial frames on an inter-byte timeout so the host can resynchronise.

Parameters:
OP_BYTES, 8, bytes per operand; operand width = 8*OP_BYTES (64 for the adder).
ADD_LATENCY, 1, cycles operands are held stable before the sum is captured (min 1).
TIMEOUT_CYC, 100000, idle cycles allowed between bytes of a partial frame; 0 disables the timeout.

Ports:
clk_i  in  1  single clock.
rst_i  in  1  reset, asynchronous, active-high.
rx_data_i  in  8  received byte.
rx_valid_i  in  1  one-cycle strobe; rx_data_i is valid.
tx_data_o  out  8  byte to transmit.
tx_valid_o  out  1  tx_data_o is valid.
tx_ready_i  in  1  transmitter accepts the byte this cycle.
add_a_o  out  8*OP_BYTES  operand A to the adder (registered).
add_b_o  out  8*OP_BYTES  operand B to the adder (registered).
add_s_i  in  8*OP_BYTES  adder sum.
add_cout_i  in  1  adder carry-out.
busy_o  out  1  high in S_WAIT and S_TX.
done_o  out  1  one-cycle pulse after the last result byte handshakes.
err_o  out  1  one-cycle pulse when a partial frame is dropped by timeout.
overrun_o  out  1  one-cycle pulse when a byte arrives in S_WAIT or S_TX (byte discarded).

Behaviour:
- Reset values, asserted asynchronously:
  - state = S_RX_A; byte counter and timeout timer = 0.
  - add_a_o, add_b_o, result register, tx_data_o = 0.
  - tx_valid_o, busy_o, done_o, err_o, overrun_o = 0.
- States: S_RX_A, S_RX_B, S_WAIT, S_TX.
- Byte ordering: LSB first. The k-th byte received (k = 0..OP_BYTES-1) is written to bits [8k+7:8k] of the operand.
- S_RX_A:
  - Each rx_valid_i writes byte k of add_a_o and increments k.
  - When byte OP_BYTES-1 is accepted: k <- 0, go to S_RX_B.
- S_RX_B: same as S_RX_A, writing add_b_o.
  - When the last byte is accepted: load the wait counter with ADD_LATENCY, go to S_WAIT.
  - add_b_o is updated in the same edge as the state change.
- S_WAIT:
  - Decrement the wait counter each cycle.
  - On the cycle the counter is 1, register result <- {7'b0, add_cout_i, add_s_i}. This is OP_BYTES+1 bytes; the last byte is the carry byte 0x00 or 0x01.
  - Go to S_TX with k = 0.
- S_TX:
  - tx_valid_o = 1 and tx_data_o = result byte k.
  - On tx_valid_o && tx_ready_i: k increments.
  - tx_data_o must stay stable while tx_valid_o && !tx_ready_i.
  - After byte OP_BYTES (the carry byte) handshakes: tx_valid_o = 0 the next cycle, done_o pulses on that cycle, state goes to S_RX_A, k = 0.
- Latency: the last B byte enters at edge N; tx_valid_o first rises at edge N+ADD_LATENCY+1.
- Operand registers hold their values until overwritten by the next frame; the adder inputs do not glitch during S_TX.
- Timeout (TIMEOUT_CYC > 0):
  - The timer runs only in S_RX_B, or in S_RX_A with k > 0.
  - It clears on every rx_valid_i.
  - When it reaches TIMEOUT_CYC: err_o pulses, state goes to S_RX_A, k = 0, timer = 0. Operand registers are not cleared.
- Simultaneous rx_valid_i and timeout expiry: the byte wins. It is accepted, the timer clears, and no err_o.
- rx_valid_i in S_WAIT or S_TX: the byte is discarded and overrun_o pulses. Counters and state are unaffected.
- Reset in any state, including mid-handshake: tx_valid_o drops asynchronously and the frame in progress is lost.
- Arithmetic is performed only by the external adder; this block does no addition. Counter widths are $clog2(OP_BYTES+1).

Decomposition:
- Shared package uart_adder_pkg holds:
  - the state enum encoding (S_RX_A = 0, S_RX_B = 1, S_WAIT = 2, S_TX = 3);
  - the default OP_BYTES constant;
  - the carry-byte format constant.
- One natural sub-module: uart_adder_timeout, a loadable down-counter with clear and expire strobe, reused for the inter-byte timeout.
- The wait counter stays inline.

Test Plan:
- Send A = 0x0000000000000001 and B = 0x0000000000000002 (LSB first, tx_ready_i tied 1) -> tx bytes 03 00 00 00 00 00 00 00 00; done_o pulses once; busy_o low afterwards.
- Send A = 0xFFFFFFFFFFFFFFFF and B = 0x0000000000000001 -> eight 00 sum bytes then carry byte 01.
- Same as case 1 with tx_ready_i low for 5 cycles on byte 0 and on byte 8 -> tx_data_o held stable while stalled; the byte sequence is unchanged; exactly 9 handshakes.
- Send 3 bytes of A, then idle TIMEOUT_CYC cycles (set TIMEOUT_CYC = 16 in the bench) -> err_o pulses exactly once at cycle 16. A following full frame A = 0x10, B = 0x20 returns 30 00.. 00 00. Also drive a byte on the exact expiry cycle -> no err_o.
- Inject two rx bytes during S_TX -> overrun_o pulses twice; transmitted result unchanged; the next frame starts cleanly at byte 0 of A.
- Assert rst_i mid-S_TX after byte 4 -> tx_valid_o low immediately; all outputs at reset values. A fresh frame with A = 5, B = 7 returns 0C, then seven 00 sum bytes, then carry byte 00.
